// File: rtl/bp_cce_pkg.sv
// rtl/bp_cce_pkg.sv - shared CCE MSHR slot state type and address helper
package bp_cce_pkg;

    typedef enum logic [1:0] {
        e_mshr_free   = 2'd0,
        e_mshr_ready  = 2'd1,
        e_mshr_active = 2'd2,
        e_mshr_wait   = 2'd3
    } bp_cce_mshr_state_e;

    // Byte offset width within a cache block; block address is paddr above it.
    function automatic int block_offset_f(input int block_width);
        return $clog2(block_width / 8);
    endfunction

endpackage

// File: rtl/bp_cce_rr_pick.sv
// rtl/bp_cce_rr_pick.sv - combinational find-first over a request vector from a start index
module bp_cce_rr_pick #(
    parameter int num_req = 4
) (
    input  logic [num_req-1:0]         req,
    input  logic [$clog2(num_req)-1:0] start,
    output logic                       v,
    output logic [$clog2(num_req)-1:0] id
);

    localparam int lg_lp = $clog2(num_req);

    logic [lg_lp-1:0] idx;

    // Scan farthest-first so the nearest request at or after start wins; index wraps naturally.
    always_comb begin
        v   = 1'b0;
        id  = '0;
        idx = '0;
        for (int k = num_req - 1; k >= 0; k--) begin
            idx = start + lg_lp'(k);
            if (req[idx]) begin
                v  = 1'b1;
                id = idx;
            end
        end
    end

endmodule

// File: rtl/bp_cce_mshr_sched.sv
// rtl/bp_cce_mshr_sched.sv - MSHR slot allocator and round-robin ucode-engine scheduler
module bp_cce_mshr_sched #(
    parameter int num_mshr_p        = 4,
    parameter int paddr_width_p     = 40,
    parameter int lce_id_width_p    = 4,
    parameter int cce_block_width_p = 512,
    parameter int lg_num_mshr_lp    = $clog2(num_mshr_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      alloc_v_i,
    input  logic [paddr_width_p-1:0]  alloc_paddr_i,
    input  logic [lce_id_width_p-1:0] alloc_lce_id_i,
    output logic                      alloc_yumi_o,
    output logic [lg_num_mshr_lp-1:0] alloc_id_o,
    output logic                      conflict_o,
    output logic                      active_v_o,
    output logic [lg_num_mshr_lp-1:0] active_id_o,
    output logic [lce_id_width_p-1:0] active_lce_id_o,
    output logic [paddr_width_p-1:0]  active_paddr_o,
    input  logic                      park_v_i,
    input  logic                      release_v_i,
    input  logic                      mem_resp_v_i,
    input  logic [lg_num_mshr_lp-1:0] mem_resp_id_i,
    output logic [num_mshr_p-1:0]     busy_o,
    output logic                      err_o
);

    import bp_cce_pkg::*;

    localparam int block_offset_lp = block_offset_f(cce_block_width_p);

    bp_cce_mshr_state_e        state_q [num_mshr_p];
    bp_cce_mshr_state_e        state_d [num_mshr_p];
    logic [paddr_width_p-1:0]  paddr_q [num_mshr_p];
    logic [lce_id_width_p-1:0] lce_q   [num_mshr_p];

    logic [lg_num_mshr_lp-1:0] rr_q;
    logic                      active_v_q;
    logic [lg_num_mshr_lp-1:0] active_id_q;
    logic [lce_id_width_p-1:0] active_lce_q;
    logic [paddr_width_p-1:0]  active_paddr_q;
    logic                      err_q;

    logic [num_mshr_p-1:0]     free_mask, ready_mask, match_mask;
    logic                      free_v, ready_v, grant;
    logic [lg_num_mshr_lp-1:0] free_id, ready_id;
    logic                      park_ok, release_ok, proto_err, resp_err, sched_en;

    always_comb begin
        free_mask  = '0;
        ready_mask = '0;
        match_mask = '0;
        for (int i = 0; i < num_mshr_p; i++) begin
            free_mask[i]  = (state_q[i] == e_mshr_free);
            ready_mask[i] = (state_q[i] == e_mshr_ready);
            match_mask[i] = !free_mask[i]
                && (paddr_q[i][paddr_width_p-1:block_offset_lp]
                    == alloc_paddr_i[paddr_width_p-1:block_offset_lp]);
        end
    end

    bp_cce_rr_pick #(.num_req(num_mshr_p)) free_pick (
        .req   (free_mask),
        .start ('0),
        .v     (free_v),
        .id    (free_id)
    );

    bp_cce_rr_pick #(.num_req(num_mshr_p)) ready_pick (
        .req   (ready_mask),
        .start (rr_q),
        .v     (ready_v),
        .id    (ready_id)
    );

    assign conflict_o   = alloc_v_i && (|match_mask);
    assign alloc_yumi_o = alloc_v_i && !conflict_o && free_v;
    assign alloc_id_o   = free_id;

    assign park_ok    = park_v_i && !release_v_i && active_v_q;
    assign release_ok = release_v_i && !park_v_i && active_v_q;
    assign proto_err  = (park_v_i && release_v_i) || ((park_v_i || release_v_i) && !active_v_q);
    assign resp_err   = mem_resp_v_i && (state_q[mem_resp_id_i] != e_mshr_wait);
    // The engine is handed over only when it is idle or the current owner leaves cleanly.
    assign sched_en   = !active_v_q || park_ok || release_ok;
    assign grant      = sched_en && ready_v;

    // Each source below touches a slot in a different state, so the writes never collide.
    always_comb begin
        state_d = state_q;
        if (alloc_yumi_o)               state_d[free_id]       = e_mshr_ready;
        if (park_ok)                    state_d[active_id_q]   = e_mshr_wait;
        if (release_ok)                 state_d[active_id_q]   = e_mshr_free;
        if (mem_resp_v_i && !resp_err)  state_d[mem_resp_id_i] = e_mshr_ready;
        if (grant)                      state_d[ready_id]      = e_mshr_active;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_mshr_p; i++) begin
                state_q[i] <= e_mshr_free;
                paddr_q[i] <= '0;
                lce_q[i]   <= '0;
            end
            rr_q           <= '0;
            active_v_q     <= 1'b0;
            active_id_q    <= '0;
            active_lce_q   <= '0;
            active_paddr_q <= '0;
            err_q          <= 1'b0;
        end else begin
            state_q <= state_d;
            if (alloc_yumi_o) begin
                paddr_q[free_id] <= alloc_paddr_i;
                lce_q[free_id]   <= alloc_lce_id_i;
            end
            if (grant) begin
                active_v_q     <= 1'b1;
                active_id_q    <= ready_id;
                active_lce_q   <= lce_q[ready_id];
                active_paddr_q <= paddr_q[ready_id];
                rr_q           <= ready_id + lg_num_mshr_lp'(1);
            end else if (park_ok || release_ok) begin
                active_v_q <= 1'b0;
            end
            if (proto_err || resp_err) err_q <= 1'b1;
        end
    end

    assign active_v_o      = active_v_q;
    assign active_id_o     = active_id_q;
    assign active_lce_id_o = active_lce_q;
    assign active_paddr_o  = active_paddr_q;
    assign busy_o          = ~free_mask;
    assign err_o           = err_q;

endmodule
